// File: rtl/spi_cmd_dispatcher.sv
// Queues 32-bit SPI command words and replays them to the system controller
// as a stable cmd_data value followed by a paced latch_data strobe.
`timescale 1ns/1ps
module spi_cmd_dispatcher #(
    parameter int DEPTH        = 8,
    parameter int SETUP_CYCLES = 1,
    parameter int LATCH_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              spi_word,
    input  logic                     spi_word_valid,
    input  logic                     dispatch_enable,
    input  logic                     hold_busy,
    input  logic                     overflow_clear,
    output logic [31:0]              cmd_data,
    output logic                     latch_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     overflow,
    output logic                     dispatch_busy,
    output logic [1:0]               state_dbg
);

    // Handshake: spi_word_valid is a one-cycle strobe with no back-pressure;
    // a word offered while full (and not relieved by a same-cycle pop) is lost
    // and recorded in the sticky overflow flag.

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int MAX_A = (SETUP_CYCLES > LATCH_CYCLES) ? SETUP_CYCLES : LATCH_CYCLES;
    localparam int MAX_C = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int TMR_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    // Timer is loaded with N-1 on state entry and the state exits at zero.
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYCLES - 1);
    localparam logic [TMR_W-1:0] LATCH_LD = TMR_W'(LATCH_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LATCH = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t             state, next_state;
    logic [TMR_W-1:0]   tmr, tmr_next;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [31:0]        mem [DEPTH];
    logic               pop;
    logic               push_ok;
    logic               push_drop;

    assign fifo_full     = (fifo_count == CNT_W'(DEPTH));
    assign fifo_empty    = (fifo_count == '0);
    assign dispatch_busy = (state != IDLE);
    assign state_dbg     = state;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok   = spi_word_valid && (!fifo_full || pop);
    assign push_drop = spi_word_valid && fifo_full && !pop;

    always_comb begin
        next_state = state;
        tmr_next   = tmr;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && dispatch_enable && !hold_busy) begin
                    pop        = 1'b1;
                    next_state = SETUP;
                    tmr_next   = SETUP_LD;
                end
            end
            SETUP: begin
                if (tmr == '0) begin
                    next_state = LATCH;
                    tmr_next   = LATCH_LD;
                end else begin
                    tmr_next = tmr - 1'b1;
                end
            end
            LATCH: begin
                if (tmr == '0) begin
                    if (GAP_CYCLES == 0) begin
                        next_state = IDLE;
                    end else begin
                        next_state = GAP;
                        tmr_next   = GAP_LD;
                    end
                end else begin
                    tmr_next = tmr - 1'b1;
                end
            end
            GAP: begin
                if (tmr == '0) begin
                    next_state = IDLE;
                end else begin
                    tmr_next = tmr - 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tmr        <= '0;
            latch_data <= 1'b0;
        end else begin
            state      <= next_state;
            tmr        <= tmr_next;
            latch_data <= (next_state == LATCH);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_data <= '0;
        end else if (pop) begin
            cmd_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= spi_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // A fresh drop outranks a clear in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (overflow_clear) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_cmd_dispatcher.sv
// Directed bench for spi_cmd_dispatcher: checks reset state, strobe timing,
// overflow, full push with pop, hold gating, pointer wrap and mid-strobe reset.
`timescale 1ns/1ps
module tb_spi_cmd_dispatcher;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] spi_word = '0;
    logic        spi_word_valid = 1'b0;
    logic        dispatch_enable = 1'b0;
    logic        hold_busy = 1'b0;
    logic        overflow_clear = 1'b0;
    logic [31:0] cmd_data;
    logic        latch_data;
    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        overflow;
    logic        dispatch_busy;
    logic [1:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic        latch_prev = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          rise_q[$];

    spi_cmd_dispatcher #(
        .DEPTH(8), .SETUP_CYCLES(1), .LATCH_CYCLES(2), .GAP_CYCLES(2)
    ) dut (
        .clock(clock), .reset(reset), .spi_word(spi_word),
        .spi_word_valid(spi_word_valid), .dispatch_enable(dispatch_enable),
        .hold_busy(hold_busy), .overflow_clear(overflow_clear),
        .cmd_data(cmd_data), .latch_data(latch_data), .fifo_count(fifo_count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
        .dispatch_busy(dispatch_busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // strobe monitor: record cmd_data and cycle at each latch_data rise
    always @(negedge clock) begin
        if (latch_data && !latch_prev) begin
            got_q.push_back(cmd_data);
            rise_q.push_back(cyc);
        end
        latch_prev = latch_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        spi_word       = w;
        spi_word_valid = 1'b1;
        step();
        spi_word_valid = 1'b0;
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(tag, got_q.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (dispatch_busy && k < budget) begin
            step();
            k++;
        end
        chk("wait_idle", dispatch_busy, 1'b0);
    endtask

    task automatic check_words(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp_q[i]);
        end
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        exp_q.delete();
        got_q.delete();
        rise_q.delete();
    endtask

    initial begin
        // reset state
        step(3);
        chk("rst_cmd", cmd_data, 32'h0);
        chk("rst_latch", latch_data, 1'b0);
        chk("rst_count", fifo_count, 4'd0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_busy", dispatch_busy, 1'b0);
        chk("rst_state", state_dbg, 2'd0);
        reset = 1'b0;
        dispatch_enable = 1'b1;
        step(2);

        // single word: push at cycle 0
        spi_word = 32'hA5A5_0001;
        spi_word_valid = 1'b1;
        step();                                     // cycle 1
        spi_word_valid = 1'b0;
        chk("sw_c1_count", fifo_count, 4'd1);
        chk("sw_c1_cmd", cmd_data, 32'h0);
        step();                                     // cycle 2
        chk("sw_c2_cmd", cmd_data, 32'hA5A5_0001);
        chk("sw_c2_empty", fifo_empty, 1'b1);
        chk("sw_c2_latch", latch_data, 1'b0);
        chk("sw_c2_busy", dispatch_busy, 1'b1);
        step();
        chk("sw_c3_latch", latch_data, 1'b1);
        step();
        chk("sw_c4_latch", latch_data, 1'b1);
        step();
        chk("sw_c5_latch", latch_data, 1'b0);
        chk("sw_c5_busy", dispatch_busy, 1'b1);
        step();
        chk("sw_c6_busy", dispatch_busy, 1'b1);
        step();
        chk("sw_c7_busy", dispatch_busy, 1'b0);
        chk("sw_c7_cmd", cmd_data, 32'hA5A5_0001);
        exp_q.push_back(32'hA5A5_0001);
        check_words("sw_word");

        // overflow
        dispatch_enable = 1'b0;
        for (int i = 1; i <= 8; i++) push(32'(i));
        chk("ovf_count8", fifo_count, 4'd8);
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_pre", overflow, 1'b0);
        push(32'h9);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count_hold", fifo_count, 4'd8);
        spi_word = 32'hA;
        spi_word_valid = 1'b1;
        overflow_clear = 1'b1;
        step();
        spi_word_valid = 1'b0;
        overflow_clear = 1'b0;
        chk("ovf_set_wins", overflow, 1'b1);
        dispatch_enable = 1'b1;
        wait_strobes("ovf_strobes", 8, 80);
        step(20);
        for (int i = 1; i <= 8; i++) exp_q.push_back(32'(i));
        check_words("ovf_word");
        chk("ovf_sticky", overflow, 1'b1);
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        chk("ovf_clear", overflow, 1'b0);
        wait_idle(20);

        // full push with simultaneous pop
        dispatch_enable = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h41 + 32'(i));
        chk("fp_count8", fifo_count, 4'd8);
        spi_word = 32'h55;
        spi_word_valid = 1'b1;
        dispatch_enable = 1'b1;
        step();
        spi_word_valid = 1'b0;
        chk("fp_count", fifo_count, 4'd8);
        chk("fp_ovf", overflow, 1'b0);
        chk("fp_cmd", cmd_data, 32'h41);
        wait_strobes("fp_strobes", 9, 80);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h41 + 32'(i));
        exp_q.push_back(32'h55);
        check_words("fp_word");
        wait_idle(20);

        // hold_busy gating
        hold_busy = 1'b1;
        push(32'h61);
        push(32'h62);
        push(32'h63);
        step(10);
        chk("hb_no_strobe", got_q.size(), 0);
        chk("hb_latch", latch_data, 1'b0);
        chk("hb_count", fifo_count, 4'd3);
        hold_busy = 1'b0;
        step();
        chk("hb_pop_busy", dispatch_busy, 1'b1);
        step();
        chk("hb_latch1", latch_data, 1'b1);
        hold_busy = 1'b1;
        step();
        chk("hb_latch2", latch_data, 1'b1);
        step();
        chk("hb_latch_end", latch_data, 1'b0);
        step(10);
        chk("hb_one_strobe", got_q.size(), 1);
        chk("hb_count2", fifo_count, 4'd2);
        chk("hb_idle", dispatch_busy, 1'b0);
        hold_busy = 1'b0;
        wait_strobes("hb_strobes", 3, 40);
        chk("hb_period", (rise_q.size() == 3) ? rise_q[2] - rise_q[1] : -1, 6);
        exp_q.push_back(32'h61);
        exp_q.push_back(32'h62);
        exp_q.push_back(32'h63);
        check_words("hb_word");
        wait_idle(20);

        // wrap-around
        for (int i = 0; i < 20; i++) begin
            push(32'h100 + 32'(i));
            step(3);
        end
        wait_strobes("wr_strobes", 20, 200);
        chk("wr_ovf", overflow, 1'b0);
        for (int i = 0; i < 20; i++) exp_q.push_back(32'h100 + 32'(i));
        check_words("wr_word");
        wait_idle(20);

        // reset mid-strobe
        dispatch_enable = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h71 + 32'(i));
        dispatch_enable = 1'b1;
        begin
            int k = 0;
            while (!latch_data && k < 20) begin
                step();
                k++;
            end
        end
        chk("rm_latch_on", latch_data, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rm_latch", latch_data, 1'b0);
        chk("rm_cmd", cmd_data, 32'h0);
        chk("rm_count", fifo_count, 4'd0);
        chk("rm_empty", fifo_empty, 1'b1);
        chk("rm_busy", dispatch_busy, 1'b0);
        step(30);
        exp_q.push_back(32'h71);
        check_words("rm_word");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
